// File: rtl/divu_seq_unit_if.sv
// Bus between ALU control / HiLo stage and the sequential unsigned divider.
// Carries function code, operands, status, results and the FSM debug state.
interface divu_seq_unit_if #(
  parameter int WIDTH = 32
);
  // Start: Signal==FUNCT_DIVU sampled in IDLE launches one op (operands sampled
  // on that edge). Completion: done is high for exactly one cycle and HiOut/LoOut/
  // div_zero are valid from that cycle until the next start. No backpressure.
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic [1:0]       dbg_state;

  modport master (
    output Signal, dataA, dataB,
    input  busy, done, div_zero, HiOut, LoOut, dbg_state
  );

  modport slave (
    input  Signal, dataA, dataB,
    output busy, done, div_zero, HiOut, LoOut, dbg_state
  );
endinterface

// File: rtl/divu_seq_unit.sv
// Sequential restoring unsigned divider: one quotient bit per clock, HI=remainder, LO=quotient.
// Optional macro DIVU_DBZ_FAST_EN: a zero divisor skips the iterations and completes next edge.
module divu_seq_unit #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] FUNCT_DIVU = 6'b011011
) (
  input  logic            clk,
  input  logic            rst,
  divu_seq_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_start;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;
  logic             w_last;

  assign w_start    = (bus.Signal == FUNCT_DIVU);
  // Partial remainder is always below the divisor, so the subtraction fits in WIDTH bits.
  assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_next = w_rem_sh[WIDTH-1:0] - (w_ge ? r_dvs : '0);
  assign w_dvd_next = {r_dvd[WIDTH-2:0], w_ge};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dvd      <= bus.dataA;
            r_dvs      <= bus.dataB;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_div_zero <= (bus.dataB == '0);
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef DIVU_DBZ_FAST_EN
          if (r_div_zero) begin
            r_hi    <= r_dvd;
            r_lo    <= '1;
            r_state <= S_DONE;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_dvd_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_hi    <= w_rem_next;
              r_lo    <= w_dvd_next;
              r_state <= S_DONE;
            end
          end
`else
          r_rem <= w_rem_next;
          r_dvd <= w_dvd_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi    <= w_rem_next;
            r_lo    <= w_dvd_next;
            r_state <= S_DONE;
          end
`endif
        end
        S_DONE: r_state <= S_HOLD;
        // A DIVU code held by control must not launch a second op.
        S_HOLD: if (!w_start) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.div_zero  = r_div_zero;
  assign bus.HiOut     = r_hi;
  assign bus.LoOut     = r_lo;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_divu_seq_unit.sv
// Self-checking bench for divu_seq_unit: vector table, corner sequences and random ops
// against an arithmetic reference model.
module tb_divu_seq_unit;
  localparam int         W     = 32;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
`ifdef DIVU_DBZ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  divu_seq_unit_if #(.WIDTH(W)) bus ();

  divu_seq_unit #(.WIDTH(W), .FUNCT_DIVU(DIVU)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } tv_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference model: plain integer division, zero divisor gives all-ones / dividend
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {b == '0, r, q};
  endfunction

  // expected timing counted in edges after the start edge
  function automatic int exp_lat(input logic [W-1:0] b);
    return (FAST && b == '0) ? 1 : W;
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                       input bit scramble);
    int lat;
    int bcnt;
    bit seen;
    bus.Signal = DIVU;
    bus.dataA  = a;
    bus.dataB  = b;
    tick();
    bus.Signal = F_ADD;
    lat  = 0;
    bcnt = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      if (bus.busy) bcnt++;
      if (bus.done) seen = 1;
      else begin
        tick();
        lat++;
        if (scramble && lat == 5) begin
          bus.dataA  = $urandom;
          bus.dataB  = $urandom;
          bus.Signal = F_SUB;
        end
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat(b)));
    chk({tag, "_hi"}, 64'(bus.HiOut), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.LoOut), 64'(elo));
    chk({tag, "_div_zero"}, 64'(bus.div_zero), 64'(edz));
    tick();
    chk({tag, "_done_pulse_1cyc"}, 64'(bus.done), 64'd0);
    chk({tag, "_hi_held"}, 64'(bus.HiOut), 64'(ehi));
    tick();
  endtask

  tv_t vec[7];

  initial begin
    logic [2*W:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int dcnt;

    vec[0] = '{32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vec[1] = '{32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0};
    vec[2] = '{32'd5,          32'd10,         32'd5,          32'd0,          1'b0};
    vec[3] = '{32'h1234_5678,  32'd0,          32'h1234_5678,  32'hFFFF_FFFF,  1'b1};
    vec[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vec[5] = '{32'h8000_0000,  32'd3,          32'd2,          32'h2AAA_AAAA,  1'b0};
    vec[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1,          1'b0};

    bus.Signal = '0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
    chk("rst_hi", 64'(bus.HiOut), 64'd0);
    chk("rst_lo", 64'(bus.LoOut), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'd0);

    // non-DIVU codes never start
    bus.Signal = 6'b111111;
    bus.dataA  = 32'd9;
    bus.dataB  = 32'd3;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.busy || bus.done) dcnt++;
    end
    chk("nonstart_111111", 64'(dcnt), 64'd0);
    bus.Signal = F_ADD;
    tick();

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vec[i].a, vec[i].b, vec[i].hi, vec[i].lo, vec[i].dz, 1'b0);

    // DIVU held for 80 cycles -> one op only
    bus.Signal = DIVU;
    bus.dataA  = 32'd100;
    bus.dataB  = 32'd7;
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.done) dcnt++;
    end
    chk("held_divu_one_done", 64'(dcnt), 64'd1);
    chk("held_divu_lo", 64'(bus.LoOut), 64'd14);
    chk("held_divu_state_hold", 64'(bus.dbg_state), 64'd3);
    bus.Signal = F_ADD;
    tick();
    do_op("after_hold", 32'd50, 32'd6, 32'd2, 32'd8, 1'b0, 1'b0);

    // reset in the middle of RUN
    bus.Signal = DIVU;
    bus.dataA  = 32'd1000;
    bus.dataB  = 32'd7;
    tick();
    bus.Signal = F_ADD;
    for (int i = 0; i < 9; i++) tick();
    chk("midrun_busy_before_rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.HiOut), 64'd0);
    chk("midrst_lo", 64'(bus.LoOut), 64'd0);
    chk("midrst_state", 64'(bus.dbg_state), 64'd0);
    do_op("post_rst", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

    // inputs scrambled mid-RUN are ignored
    do_op("scramble", 32'd1000, 32'd9, 32'd1, 32'd111, 1'b0, 1'b1);

    // random ops against the model
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      m = model(ra, rb);
      do_op($sformatf("rand%0d", i), ra, rb, m[2*W-1:W], m[W-1:0], m[2*W], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
